// File: rtl/cdr_loop_ctrl.sv
// CDR loop sequencer: accumulates phase-detector votes per transition window, issues
// held +/- period-step requests to the divider and runs the ACQ/TRACK/LOCK state machine.
module cdr_loop_ctrl #(
  parameter int ACQ_WIN   = 4,
  parameter int ACQ_THR   = 2,
  parameter int TRK_WIN   = 16,
  parameter int TRK_THR   = 8,
  parameter int ACQ_QUIET = 2,
  parameter int LOCK_WIN  = 4,
  parameter int TIMEOUT   = 64,
  parameter int MAX_STEP  = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_sym_en,
  input  logic              i_T,
  input  logic              i_E,
  input  logic              i_upd,
  output logic              o_T,
  output logic              o_E,
  output logic signed [2:0] o_offset,
  output logic [1:0]        o_state,
  output logic              o_lock,
  output logic              o_sat
);

  localparam int VOTE_W = $clog2(TRK_WIN) + 2;
  localparam int WC_W   = $clog2(TRK_WIN) + 1;
  localparam int TW     = $clog2(TIMEOUT) + 1;
  localparam int QW     = $clog2(ACQ_QUIET + LOCK_WIN) + 1;

  localparam logic signed [VOTE_W-1:0] ACQ_T   = VOTE_W'(ACQ_THR);
  localparam logic signed [VOTE_W-1:0] TRK_T   = VOTE_W'(TRK_THR);
  localparam logic signed [VOTE_W-1:0] V_ONE   = VOTE_W'(1);
  localparam logic [WC_W-1:0]          ACQ_L   = WC_W'(ACQ_WIN - 1);
  localparam logic [WC_W-1:0]          TRK_L   = WC_W'(TRK_WIN - 1);
  localparam logic [TW-1:0]            TMO_L   = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0]            TMO_MAX = TW'(TIMEOUT);
  localparam logic [QW-1:0]            AQ_L    = QW'(ACQ_QUIET - 1);
  localparam logic [QW-1:0]            LK_L    = QW'(LOCK_WIN - 1);
  localparam logic signed [2:0]        OFF_MAX = 3'(MAX_STEP);

  typedef enum logic [1:0] {IDLE = 2'd0, ACQ = 2'd1, TRACK = 2'd2, LOCK = 2'd3} state_t;

  state_t                    state, state_nx;
  logic signed [VOTE_W-1:0]  vote, vote_sum, thr;
  logic [WC_W-1:0]           win_cnt, win_last;
  logic [TW-1:0]             tmo_cnt;
  logic [QW-1:0]             q_cnt;
  logic                      active, tick, win_end, dec_up, dec_dn, quiet, tmo_hit;
  logic                      iss_up, iss_dn;
  logic signed [2:0]         off_nx;

  function automatic logic signed [2:0] step_off(input logic signed [2:0] v, input logic up);
    if (up) return (v >= OFF_MAX) ? OFF_MAX : v + 3'sd1;
    else    return (v <= -OFF_MAX) ? -OFF_MAX : v - 3'sd1;
  endfunction

  function automatic logic at_limit(input logic signed [2:0] v);
    return (v == OFF_MAX) || (v == -OFF_MAX);
  endfunction

  always_comb begin
    active   = i_en && (state != IDLE);
    tick     = active && i_sym_en && i_T;
    vote_sum = vote + (i_E ? V_ONE : -V_ONE);
    thr      = (state == ACQ) ? ACQ_T : TRK_T;
    win_last = (state == ACQ) ? ACQ_L : TRK_L;
    win_end  = tick && (win_cnt == win_last);
    dec_up   = win_end && (vote_sum >= thr);
    dec_dn   = win_end && (vote_sum <= -thr);
    quiet    = win_end && !dec_up && !dec_dn;
    tmo_hit  = active && i_sym_en && !i_T && (tmo_cnt == TMO_L) &&
               ((state == TRACK) || (state == LOCK));
    // A decision only becomes a request when nothing is pending and the offset has room.
    iss_up   = dec_up && !o_T && (o_offset != OFF_MAX);
    iss_dn   = dec_dn && !o_T && (o_offset != -OFF_MAX);
    off_nx   = (i_en && o_T && i_upd) ? step_off(o_offset, o_E) : o_offset;

    state_nx = state;
    if (!i_en)               state_nx = IDLE;
    else if (state == IDLE)  state_nx = ACQ;
    else if (tmo_hit)        state_nx = ACQ;
    else if (win_end) begin
      case (state)
        ACQ:     if (quiet && q_cnt == AQ_L) state_nx = TRACK;
        TRACK:   if (quiet && q_cnt == LK_L) state_nx = LOCK;
        LOCK:    if (!quiet)                 state_nx = TRACK;
        default: state_nx = state;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      o_T      <= 1'b0;
      o_E      <= 1'b0;
      o_offset <= '0;
      o_lock   <= 1'b0;
      o_sat    <= 1'b0;
      vote     <= '0;
      win_cnt  <= '0;
      q_cnt    <= '0;
      tmo_cnt  <= '0;
    end else begin
      state    <= state_nx;
      o_lock   <= (state_nx == LOCK);
      o_offset <= off_nx;
      o_sat    <= at_limit(off_nx);

      if (!i_en) o_T <= 1'b0;
      else if (o_T) begin
        if (i_upd) o_T <= 1'b0;
      end else if (iss_up || iss_dn) begin
        o_T <= 1'b1;
        o_E <= iss_up;
      end

      if (!active || tmo_hit) begin
        vote    <= '0;
        win_cnt <= '0;
        q_cnt   <= '0;
        tmo_cnt <= '0;
      end else begin
        // ACQ lets the silence counter park at TIMEOUT; TRACK/LOCK never get past TIMEOUT-1.
        if (i_sym_en) begin
          if (i_T)                       tmo_cnt <= '0;
          else if (tmo_cnt != TMO_MAX)   tmo_cnt <= tmo_cnt + TW'(1);
        end
        if (win_end) begin
          vote    <= '0;
          win_cnt <= '0;
        end else if (tick) begin
          vote    <= vote_sum;
          win_cnt <= win_cnt + WC_W'(1);
        end
        if (state_nx != state) q_cnt <= '0;
        else if (win_end)      q_cnt <= quiet ? q_cnt + QW'(1) : '0;
      end
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_cdr_loop_ctrl.sv
// Directed bench for cdr_loop_ctrl: a per-cycle vector table for acquisition and
// hand-written window sequences for tracking, lock, handshake and timeout corners.
module tb_cdr_loop_ctrl;

  logic              clk = 1'b0;
  logic              rst, en, sym_en, t_in, e_in, upd;
  logic              o_T, o_E, o_lock, o_sat;
  logic signed [2:0] o_offset;
  logic [1:0]        o_state;

  int n_tests = 0;
  int n_fail  = 0;

  cdr_loop_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_sym_en(sym_en), .i_T(t_in), .i_E(e_in),
    .i_upd(upd), .o_T(o_T), .o_E(o_E), .o_offset(o_offset), .o_state(o_state),
    .o_lock(o_lock), .o_sat(o_sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en, sym, t, e, upd;
    logic [8:0] exp;
  } vec_t;

  vec_t vt[24];

  function automatic logic [8:0] pk(input logic xt, xe, input int off, input int st,
                                    input logic xl, xs);
    logic [2:0] o3;
    logic [1:0] s2;
    o3 = 3'(off);
    s2 = 2'(st);
    return {xt, xe, o3, s2, xl, xs};
  endfunction

  function automatic vec_t mk(input logic a_en, a_sym, a_t, a_e, a_upd, input logic [8:0] x);
    vec_t v;
    v.en = a_en; v.sym = a_sym; v.t = a_t; v.e = a_e; v.upd = a_upd; v.exp = x;
    return v;
  endfunction

  function automatic logic [8:0] outs();
    return {o_T, o_E, o_offset, o_state, o_lock, o_sat};
  endfunction

  task automatic chk(input string name, input logic [8:0] got, input logic [8:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got {T,E,off,st,lock,sat}=%b required %b", name, got, exp);
    end
  endtask

  task automatic cyc(input logic a_en, a_sym, a_t, a_e, a_upd);
    en = a_en; sym_en = a_sym; t_in = a_t; e_in = a_e; upd = a_upd;
    @(posedge clk);
    #1;
  endtask

  // n transitions alternating early/late starting early: vote ends at 0
  task automatic alt_win(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 1'b1, (i % 2) == 0, 1'b0);
  endtask

  // ne early then nl late transitions; i_upd raised on the last one if upd_last
  task automatic seq_win(input int ne, input int nl, input logic upd_last);
    for (int i = 0; i < ne + nl; i++)
      cyc(1'b1, 1'b1, 1'b1, i < ne, upd_last && (i == ne + nl - 1));
  endtask

  initial begin
    // acquisition: up step, saturation block, down step, two quiet windows -> TRACK
    vt[0] = mk(1, 0, 0, 0, 0, pk(0, 0, 0, 1, 0, 0));
    for (int i = 1; i <= 3; i++) vt[i] = mk(1, 1, 1, 1, 0, pk(0, 0, 0, 1, 0, 0));
    vt[4] = mk(1, 1, 1, 1, 0, pk(1, 1, 0, 1, 0, 0));
    vt[5] = mk(1, 0, 0, 0, 1, pk(0, 1, 1, 1, 0, 1));
    for (int i = 6; i <= 9; i++) vt[i] = mk(1, 1, 1, 1, 0, pk(0, 1, 1, 1, 0, 1));
    for (int i = 10; i <= 12; i++) vt[i] = mk(1, 1, 1, 0, 0, pk(0, 1, 1, 1, 0, 1));
    vt[13] = mk(1, 1, 1, 1, 0, pk(1, 0, 1, 1, 0, 1));
    vt[14] = mk(1, 0, 0, 0, 1, pk(0, 0, 0, 1, 0, 0));
    vt[15] = mk(1, 0, 0, 0, 1, pk(0, 0, 0, 1, 0, 0));
    for (int i = 16; i <= 22; i++)
      vt[i] = mk(1, 1, 1, (i % 2) == 0, 0, pk(0, 0, 0, 1, 0, 0));
    vt[23] = mk(1, 1, 1, 0, 0, pk(0, 0, 0, 2, 0, 0));

    rst = 1'b1; en = 1'b0; sym_en = 1'b0; t_in = 1'b0; e_in = 1'b0; upd = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", outs(), pk(0, 0, 0, 0, 0, 0));
    rst = 1'b0;
    cyc(0, 0, 0, 0, 0);
    chk("idle_en_low", outs(), pk(0, 0, 0, 0, 0, 0));

    for (int i = 0; i < 24; i++) begin
      cyc(vt[i].en, vt[i].sym, vt[i].t, vt[i].e, vt[i].upd);
      chk($sformatf("vec%0d", i), outs(), vt[i].exp);
    end

    // four quiet TRACK windows -> LOCK
    for (int w = 0; w < 3; w++) alt_win(16);
    chk("track_3_quiet", outs(), pk(0, 0, 0, 2, 0, 0));
    alt_win(16);
    chk("lock_entry", outs(), pk(0, 0, 0, 3, 1, 0));

    // vote +8 in LOCK: request up and fall back to TRACK together
    seq_win(12, 4, 1'b0);
    chk("lock_vote8", outs(), pk(1, 1, 0, 2, 0, 0));

    // request withheld: a full qualifying window issues nothing new
    seq_win(15, 0, 1'b0);
    chk("held_midwin", outs(), pk(1, 1, 0, 2, 0, 0));
    cyc(1, 1, 1, 0, 0);
    chk("held_win_end", outs(), pk(1, 1, 0, 2, 0, 0));

    // ack coincident with a window end: offset steps, no new request
    seq_win(16, 0, 1'b1);
    chk("upd_at_win_end", outs(), pk(0, 1, 1, 2, 0, 1));

    // back to LOCK at offset +1, then 64 silent symbols -> ACQ
    for (int w = 0; w < 4; w++) alt_win(16);
    chk("relock", outs(), pk(0, 1, 1, 3, 1, 1));
    for (int i = 0; i < 63; i++) cyc(1, 1, 0, 0, 0);
    chk("tmo_63", outs(), pk(0, 1, 1, 3, 1, 1));
    cyc(1, 1, 0, 0, 0);
    chk("tmo_64", outs(), pk(0, 1, 1, 1, 0, 1));

    // timeout has no effect in ACQ
    for (int i = 0; i < 70; i++) cyc(1, 1, 0, 0, 0);
    chk("acq_tmo_sat", outs(), pk(0, 1, 1, 1, 0, 1));

    // down request from +1, then disable with an ack present: no offset change
    seq_win(0, 4, 1'b0);
    chk("acq_down_req", outs(), pk(1, 0, 1, 1, 0, 1));
    cyc(0, 0, 0, 0, 1);
    chk("en_drop", outs(), pk(0, 0, 1, 0, 0, 1));
    cyc(1, 0, 0, 0, 0);
    chk("reenable", outs(), pk(0, 0, 1, 1, 0, 1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cdr_loop_ctrl.md
Name: cdr_loop_ctrl

Overview:
- Sequencing controller for the CDR period-adjust divider.
- Accumulates early/late votes from the phase detector over transition windows and decides when a one-step period correction is needed.
- Issues that correction to the divider as a held request/acknowledge pair and tracks the resulting period offset.
- Runs an acquisition/track/lock state machine and drives the lock and saturation status for the receiver.

Parameters:
- ACQ_WIN, 4: transitions per acquisition window.
- ACQ_THR, 2: |vote| needed to adjust in ACQ.
- TRK_WIN, 16: transitions per window in TRACK and LOCK.
- TRK_THR, 8: |vote| needed to adjust in TRACK and LOCK.
- ACQ_QUIET, 2: consecutive quiet ACQ windows before entering TRACK.
- LOCK_WIN, 4: consecutive quiet TRACK windows before entering LOCK.
- TIMEOUT, 64: consecutive symbols without a transition that count as signal loss.
- MAX_STEP, 1: maximum |offset| in divider steps. One step is ±2 clock periods, so nb_P stays within 23..27.

Ports:
- i_clk, in, 1: system clock (50 MHz).
- i_rst, in, 1: synchronous reset, active-high.
- i_en, in, 1: loop enable. Low forces IDLE.
- i_sym_en, in, 1: one-cycle strobe per symbol sample opportunity.
- i_T, in, 1: transition detected. Valid only with i_sym_en.
- i_E, in, 1: 1 = sampling early (needs +period), 0 = late (needs −period). Valid with i_T.
- i_upd, in, 1: divider update strobe. Acknowledges the request.
- o_T, out, 1: adjust request to the divider. Held until acknowledged.
- o_E, out, 1: adjust direction. 1 = +2 periods, 0 = −2 periods. Stable while o_T is high.
- o_offset, out, 3: signed accumulated step offset, range −MAX_STEP..+MAX_STEP.
- o_state, out, 2: IDLE=0, ACQ=1, TRACK=2, LOCK=3.
- o_lock, out, 1: high iff state is LOCK.
- o_sat, out, 1: high while |o_offset| == MAX_STEP.

Behaviour:
- Reset: state IDLE, o_T=0, o_E=0, o_offset=0, o_lock=0, o_sat=0. Vote, window, quiet and timeout counters cleared.
- i_en=0 in any state: next state IDLE. Any pending o_T drops next cycle with no offset change. All counters are cleared; o_offset is kept.
- IDLE to ACQ when i_en=1.
- Vote accounting: each cycle with i_sym_en & i_T adds +1 to the vote if i_E=1, −1 if i_E=0, and increments the window count.
- Vote width is signed $clog2(TRK_WIN)+2 bits, with no overflow possible. WIN and THR follow the current state.
- Window end is the cycle in which the window count reaches WIN. That transition is included in the vote. Vote and window count clear in the same cycle.
- Decision at window end:
  - vote ≥ THR gives an up decision.
  - vote ≤ −THR gives a down decision.
  - Otherwise the window is quiet.
- A decision is issued only if no request is pending at the start of that cycle and the offset is not at the limit in that direction. An issued decision sets o_T=1 and o_E=dir on the next cycle (latency 1).
- A decision blocked by a pending request or by saturation is dropped. It still counts as non-quiet.
- Handshake: o_T and o_E are held until a cycle with i_upd=1 and o_T=1. In that cycle o_offset changes by ±1, and o_T=0 on the next cycle. i_upd while o_T=0 is ignored.
- Quiet counting: a quiet window increments the quiet counter; a non-quiet window clears it.
  - ACQ to TRACK when the quiet count reaches ACQ_QUIET.
  - TRACK to LOCK when the quiet count reaches LOCK_WIN.
  - LOCK to TRACK on any non-quiet window.
  - Every state change clears the quiet, vote and window counters.
- Timeout: the counter increments on i_sym_en & !i_T and clears on i_sym_en & i_T.
  - Reaching TIMEOUT in TRACK or LOCK moves the state to ACQ and clears all counters. o_offset and a pending request are kept.
  - In ACQ the timeout counter saturates at TIMEOUT and has no effect.
- Simultaneous events: i_upd and a window end in the same cycle means the decision sees pending=1 and is dropped.
- Priority order: i_rst > i_en=0 > timeout > window-end transition.
- o_sat and o_lock are registered from the updated o_offset and state.

Test Plan:
- Reset, then i_en=1, then 4 transitions with i_E=1: o_state goes 0→1, o_T=1 and o_E=1 one cycle after the 4th transition. With i_upd pulsed, o_offset=1 and o_sat=1.
- With offset=+1, ACQ window of 4 early votes: no o_T (saturated), quiet counter cleared. A later window of 3 late + 1 early gives vote −2, so o_T=1, o_E=0, and after ack offset=0.
- Alternating i_E over 2 ACQ windows gives TRACK. 4 quiet TRACK windows (16 transitions each, vote 0) give LOCK and o_lock=1.
- In LOCK, a window with 12 early and 4 late (vote 8) gives o_T=1, o_E=1, state TRACK and o_lock=0 on the window-end cycle.
- Withhold i_upd: o_T stays high for a full window, and a second qualifying window-end issues no new request (o_E unchanged). i_upd in the same cycle as a window end gives offset +1, o_T=0, and no new request.
- In LOCK, 64 i_sym_en strobes with i_T=0 give state ACQ with o_offset preserved. Dropping i_en mid-request gives o_T=0 and state IDLE on the next cycle.
